// File: rtl/fir_pkg.sv
// fir_pkg: shared types and defaults for the FIR datapath and its coefficient controller.
package fir_pkg;
  localparam int TAPS_DEF = 100;
  localparam int COEF_WIDTH_DEF = 16;
  localparam int SETTLE_DEF = TAPS_DEF + 3;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ARMED, S_SWAP, S_SETTLE} state_t;
  typedef logic signed [COEF_WIDTH_DEF-1:0] coef_t;
  typedef coef_t coef_arr_t [TAPS_DEF];
endpackage

// File: rtl/fir_coef_ctrl_if.sv
// fir_coef_ctrl_if: coefficient stream and load/swap request bundle.
interface fir_coef_ctrl_if import fir_pkg::*; #(
  parameter int COEF_WIDTH = COEF_WIDTH_DEF
);
  logic load_start;
  logic coef_valid;
  logic coef_ready;
  logic swap_req;
  logic signed [COEF_WIDTH-1:0] coef_data;
  logic [31:0] chk_ref;
  modport master(output load_start, coef_valid, coef_data, swap_req, chk_ref, input coef_ready);
  modport slave(input load_start, coef_valid, coef_data, swap_req, chk_ref, output coef_ready);
endinterface

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: shadow/active coefficient registers with indexed write and whole-bank copy.
module fir_coef_bank import fir_pkg::*; #(
  parameter int TAPS = TAPS_DEF,
  parameter int COEF_WIDTH = COEF_WIDTH_DEF,
  parameter int IW = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic signed [COEF_WIDTH-1:0] wr_data,
  input  logic copy,
  output logic signed [COEF_WIDTH-1:0] active [TAPS]
);
  logic signed [COEF_WIDTH-1:0] shadow [TAPS];
  always_ff @(posedge clk)
    if (rst) begin
      shadow <= '{default: '0};
      active <= '{default: '0};
    end else begin
      if (wr_en) shadow[wr_idx] <= wr_data;
      if (copy) active <= shadow;
    end
endmodule

// File: rtl/fir_coef_ctrl.sv
// fir_coef_ctrl: loads a shadow coefficient set, commits it atomically and masks y until flushed.
// Optional FIR_COEF_CHECKSUM_EN gates arming on a 32-bit sum matching chk_ref.
module fir_coef_ctrl import fir_pkg::*; #(
  parameter int TAPS = TAPS_DEF,
  parameter int COEF_WIDTH = COEF_WIDTH_DEF,
  parameter int SETTLE = TAPS + 3
) (
  input  logic clk,
  input  logic rst,
  fir_coef_ctrl_if.slave bus,
  output logic signed [COEF_WIDTH-1:0] coef_active [TAPS],
  output logic armed,
  output logic busy,
  output logic y_valid,
  output logic err
);
  localparam int IW = TAPS > 1 ? $clog2(TAPS) : 1;
  localparam int CW = $clog2(SETTLE + 1);
  state_t state, next;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic beat, last, chk_ok, start_ok;
  assign start_ok = bus.load_start && state inside {S_IDLE, S_LOAD, S_ARMED};
  // a restart in the same cycle as a beat discards that beat
  assign beat = state == S_LOAD && bus.coef_valid && !bus.load_start;
  assign last = idx == IW'(TAPS - 1);
`ifdef FIR_COEF_CHECKSUM_EN
  logic [31:0] sum, sum_nx;
  assign sum_nx = sum + 32'($signed(bus.coef_data));
  assign chk_ok = sum_nx == bus.chk_ref;
  always_ff @(posedge clk)
    if (rst || start_ok) sum <= '0;
    else if (beat) sum <= sum_nx;
`else
  logic unused_chk;
  assign unused_chk = ^bus.chk_ref;
  assign chk_ok = 1'b1;
`endif
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      S_IDLE:   next = start_ok ? S_LOAD : S_IDLE;
      S_LOAD:   next = start_ok ? S_LOAD : (beat && last) ? (chk_ok ? S_ARMED : S_IDLE) : S_LOAD;
      S_ARMED:  next = start_ok ? S_LOAD : bus.swap_req ? S_SWAP : S_ARMED;
      S_SWAP:   next = S_SETTLE;
      S_SETTLE: next = cnt == '0 ? S_IDLE : S_SETTLE;
      default:  next = S_IDLE;
    endcase
  end
  always_comb begin
    bus.coef_ready = state == S_LOAD;
    armed = state == S_ARMED;
    busy = state inside {S_LOAD, S_SWAP, S_SETTLE};
  end
  always_ff @(posedge clk)
    if (rst) begin
      idx <= '0;
      cnt <= '0;
      y_valid <= 1'b0;
      err <= 1'b0;
    end else begin
      idx <= (start_ok || (beat && last)) ? '0 : beat ? idx + 1'b1 : idx;
      cnt <= state == S_SWAP ? CW'(SETTLE - 1) : (state == S_SETTLE && cnt != '0) ? cnt - 1'b1 : cnt;
      y_valid <= state == S_SWAP ? 1'b0 : (state == S_SETTLE && cnt == '0) ? 1'b1 : y_valid;
      err <= (bus.swap_req && (state != S_ARMED || bus.load_start))
          || (bus.load_start && state inside {S_SWAP, S_SETTLE})
          || (beat && last && !chk_ok);
    end
  fir_coef_bank #(.TAPS(TAPS), .COEF_WIDTH(COEF_WIDTH), .IW(IW)) u_bank (
    .clk(clk),
    .rst(rst),
    .wr_en(beat),
    .wr_idx(idx),
    .wr_data(bus.coef_data),
    .copy(state == S_SWAP),
    .active(coef_active)
  );
endmodule

// File: tb/tb_fir_coef_ctrl.sv
// tb_fir_coef_ctrl: directed plus randomized stimulus against a queue-based behavioural model.
module tb_fir_coef_ctrl;
  localparam int T = 4;
  localparam int W = 16;
  localparam int S = 7;
  logic clk, rst;
  logic signed [W-1:0] coef_active [T];
  logic armed, busy, y_valid, err;
  int checks = 0, errors = 0;
  fir_coef_ctrl_if #(.COEF_WIDTH(W)) bus();
  fir_coef_ctrl #(.TAPS(T), .COEF_WIDTH(W), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .bus(bus), .coef_active(coef_active),
    .armed(armed), .busy(busy), .y_valid(y_valid), .err(err)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  // model: loading/armed flags, a queue of accepted beats, remaining settle cycles
  bit m_load, m_arm, m_swap, m_yv, m_err;
  int m_left;
  int m_sh[$];
  int m_act[T];
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int qsum();
    int s = 0;
    foreach (m_sh[i]) s += m_sh[i];
    return s;
  endfunction
  function automatic bit sum_ok(int r);
`ifdef FIR_COEF_CHECKSUM_EN
    return qsum() == r;
`else
    return 1'b1;
`endif
  endfunction
  task automatic model(bit r, bit ls, bit v, int d, bit sw, int rf);
    bit e = 0;
    if (r) begin
      m_load = 0; m_arm = 0; m_swap = 0; m_left = 0; m_yv = 0; m_err = 0;
      m_sh.delete();
      foreach (m_act[i]) m_act[i] = 0;
      return;
    end
    if (m_swap) begin
      foreach (m_act[i]) m_act[i] = m_sh[i];
      m_swap = 0; m_left = S; m_yv = 0; e = ls || sw;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_yv = 1;
      e = ls || sw;
    end else if (ls) begin
      e = sw; m_load = 1; m_arm = 0; m_sh.delete();
    end else if (m_load) begin
      e = sw;
      if (v) begin
        m_sh.push_back(d);
        if (m_sh.size() == T) begin
          m_load = 0;
          if (sum_ok(rf)) m_arm = 1;
          else e = 1;
        end
      end
    end else if (m_arm) begin
      if (sw) begin m_arm = 0; m_swap = 1; end
    end else e = sw;
    m_err = e;
  endtask
  task automatic cyc(bit r, bit ls, bit v, int d, bit sw, int rf);
    rst = r; bus.load_start = ls; bus.coef_valid = v; bus.coef_data = W'(d);
    bus.swap_req = sw; bus.chk_ref = rf;
    @(posedge clk);
    model(r, ls, v, d, sw, rf);
    @(negedge clk);
    check("coef_ready", int'(bus.coef_ready), int'(m_load));
    check("armed", int'(armed), int'(m_arm));
    check("busy", int'(busy), int'(m_load || m_swap || m_left > 0));
    check("y_valid", int'(y_valid), int'(m_yv));
    check("err", int'(err), int'(m_err));
    for (int i = 0; i < T; i++) check($sformatf("active%0d", i), int'(coef_active[i]), m_act[i]);
  endtask
  task automatic idle(int n, bit sw = 0);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, sw, 0);
  endtask
  task automatic load(input int vals[T], int n, int rf);
    cyc(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      for (int g = $urandom_range(0, 2); g > 0; g--) cyc(0, 0, 0, int'($urandom_range(0, 999)), 0, rf);
      cyc(0, 0, 1, vals[i], 0, rf);
    end
  endtask
  initial begin
    int d, rf;
    bit ls, sw, v, r;
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("reset_yv", int'(y_valid), 0);
    load('{1, 2, 3, 4}, T, 10);
    check("armed_first", int'(armed), 1);
    check("active_still0", int'(coef_active[3]), 0);
    idle(2);
    cyc(0, 0, 0, 0, 1, 0);
    idle(1);
    check("commit_t3", int'(coef_active[3]), 4);
    check("yv_low", int'(y_valid), 0);
    idle(S);
    check("yv_high", int'(y_valid), 1);
    for (int i = 0; i < T; i++) check("impulse", int'(coef_active[i]), i + 1);
    idle(1, 1);
    load('{5, 6, 7, 8}, 2, 0);
    load('{5, 6, 7, 8}, T, 26);
    cyc(0, 0, 0, 0, 1, 0);
    idle(3);
    idle(1, 1);
    cyc(0, 1, 0, 0, 0, 0);
    idle(S);
    check("restart_commit", int'(coef_active[0]), 5);
    load('{9, 10, 11, 12}, T, 42);
    cyc(0, 1, 0, 0, 1, 0);
    check("ls_sw_err", int'(err), 1);
    check("ls_sw_load", int'(bus.coef_ready), 1);
    load('{1, 2, 3, 4}, T, 11);
    idle(1);
    cyc(0, 0, 0, 0, 1, 0);
    idle(S + 2);
    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 499) == 0;
      ls = $urandom_range(0, 39) == 0;
      sw = $urandom_range(0, 29) == 0;
      v = $urandom_range(0, 9) < 7;
      d = int'($urandom_range(0, 65535)) - 32768;
      rf = int'($urandom);
      if (m_load && m_sh.size() == T - 1 && $urandom_range(0, 99) < 85) rf = qsum() + d;
      cyc(r, ls, v, d, sw, rf);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
